// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between a master (testbench/driver) and apb_slave_mem.
// The master drives the address, control and write data. The slave returns read data and ready.
interface apb_slave_mem_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PWRITE;
  logic                  PSEL;
  logic                  PENABLE;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB3 word-addressed memory slave with a fixed number of wait states per access.
// Setup captures the transfer. A countdown then raises PREADY for one cycle, and the transfer commits on the following edge.
module apb_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_slave_mem_if.slave    apb
);
  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT  = 4'(WAIT_CYCLES);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [AW-1:0]         addr_q;
  logic                  in_range_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pready_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  setup;
  logic [AW-1:0]         paddr_idx;
  logic                  paddr_ok;
  logic [DATA_WIDTH-1:0] setup_rd;
  logic [DATA_WIDTH-1:0] access_rd;
  logic                  unused_byte_lanes;

  assign setup             = apb.PSEL && !apb.PENABLE;
  assign paddr_idx         = apb.PADDR[AW+1:2];
  assign paddr_ok          = (apb.PADDR[31:AW+2] == '0);
  assign unused_byte_lanes = ^apb.PADDR[1:0];
  // Out-of-range reads return zero instead of aliasing onto a real word.
  assign setup_rd          = paddr_ok   ? mem_q[paddr_idx] : '0;
  assign access_rd         = in_range_q ? mem_q[addr_q]    : '0;

  // NOTE: the memory array is cleared by reset, so it is built from flops and not from a RAM macro.
  // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      in_range_q <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (setup) begin
      // A setup seen in ACCESS abandons the old transfer and starts this one.
      state_q    <= ACCESS;
      cnt_q      <= CNT_INIT;
      addr_q     <= paddr_idx;
      in_range_q <= paddr_ok;
      write_q    <= apb.PWRITE;
      wdata_q    <= apb.PWDATA;
      pready_q   <= ZERO_WAIT;
      if (ZERO_WAIT && !apb.PWRITE) prdata_q <= setup_rd;
    end else if (state_q == ACCESS) begin
      if (!apb.PSEL) begin
        state_q  <= IDLE;
        pready_q <= 1'b0;
        cnt_q    <= '0;
      end else if (!pready_q) begin
        cnt_q    <= cnt_q - 4'd1;
        pready_q <= (cnt_q == 4'd1);
        if (cnt_q == 4'd1 && !write_q) prdata_q <= access_rd;
      end else begin
        if (write_q && in_range_q) mem_q[addr_q] <= wdata_q;
        pready_q <= 1'b0;
        state_q  <= IDLE;
      end
    end
  end

  assign apb.PRDATA = prdata_q;
  assign apb.PREADY = pready_q;
endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed and randomized APB traffic against apb_slave_mem, checked against an array model of the word memory.
module tb_apb_slave_mem;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int WAITS = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  apb_slave_mem_if #(.DATA_WIDTH(DW)) bus ();

  apb_slave_mem #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WAITS)) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .apb     (bus)
  );

  int passes = 0;
  int total  = 0;

  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] prdata_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] model_read(input logic [31:0] addr);
    if (addr < 4 * DEPTH) return mem_m[addr / 4];
    return '0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    prdata_m = '0;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // One full transfer. It returns just after the completion edge, so a following call runs back-to-back.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [DW-1:0] data, input string tag);
    int            cycles;
    bit            done;
    logic [DW-1:0] rd;
    rd = 'x;
    done = 1'b0;
    @(negedge clk);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = data;
    @(posedge clk);
    cycles = 1;
    @(negedge clk);
    // The slave must ignore these mid-transfer changes.
    bus.PENABLE = 1'b1;
    bus.PADDR   = $urandom;
    bus.PWDATA  = $urandom;
    bus.PWRITE  = 1'($urandom_range(0, 1));
    for (int i = 0; i < 40 && !done; i++) begin
      if (bus.PREADY === 1'b1) begin
        rd   = bus.PRDATA;
        done = 1'b1;
      end
      @(posedge clk);
      cycles++;
      if (!done) @(negedge clk);
    end
    #1;
    check({tag, " ready_seen"}, 64'(done), 64'd1);
    check({tag, " cycles"}, 64'(cycles), 64'(2 + WAITS));
    check({tag, " ready_drop"}, 64'(bus.PREADY), 64'd0);
    if (wr) begin
      if (addr < 4 * DEPTH) mem_m[addr / 4] = data;
    end else begin
      prdata_m = model_read(addr);
      check({tag, " rdata"}, 64'(rd), 64'(prdata_m));
    end
    check({tag, " prdata_hold"}, 64'(bus.PRDATA), 64'(prdata_m));
  endtask

  initial begin
    int ready_hits;
    bit wr;
    logic [31:0] a;
    model_clear();
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;

    // Reset held for three cycles.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset pready", 64'(bus.PREADY), 64'd0);
    check("reset prdata", 64'(bus.PRDATA), 64'd0);
    rst_n = 1'b1;
    xfer(1'b0, 32'h0, '0, "reset_rd0");

    // Basic write and read-back with timing checks.
    xfer(1'b1, 32'h10, 32'hA5A5_1234, "wr10");
    xfer(1'b0, 32'h10, '0, "rd10");

    // Back-to-back fill of the whole array with data = address, then read back.
    for (int i = 0; i < DEPTH; i++) xfer(1'b1, 32'(4 * i), 32'(4 * i), "fill_wr");
    for (int i = 0; i < DEPTH; i++) xfer(1'b0, 32'(4 * i), '0, "fill_rd");

    // Out-of-range write is dropped. The read returns zero and does not alias word 0.
    xfer(1'b1, 32'h100, 32'hFFFF_FFFF, "oor_wr");
    xfer(1'b0, 32'h100, '0, "oor_rd");
    xfer(1'b0, 32'h0, '0, "oor_rd0");
    // Low address bits are ignored.
    xfer(1'b0, 32'h13, '0, "unaligned_rd");

    // Abort: PSEL drops after one access cycle.
    @(negedge clk);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h20; bus.PWDATA = 32'h1111_1111;
    @(negedge clk);
    bus.PENABLE = 1'b1;
    @(negedge clk);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    ready_hits = 0;
    for (int i = 0; i < 2 * WAITS + 4; i++) begin
      @(negedge clk);
      if (bus.PREADY !== 1'b0) ready_hits++;
    end
    check("abort no_ready", 64'(ready_hits), 64'd0);
    check("abort prdata", 64'(bus.PRDATA), 64'(prdata_m));
    xfer(1'b0, 32'h20, '0, "abort_rd20");

    // Reset during the wait states of a write.
    idle(1);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h30; bus.PWDATA = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.PENABLE = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst pready", 64'(bus.PREADY), 64'd0);
    check("midrst prdata", 64'(bus.PRDATA), 64'd0);
    model_clear();
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer(1'b0, 32'h30, '0, "midrst_rd30");
    xfer(1'b0, 32'h10, '0, "midrst_rd10");

    // Randomized mix of reads and writes, some out of range, with random idle gaps.
    for (int n = 0; n < 150; n++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) a = 32'($urandom_range(0, 4 * DEPTH - 1));
      else a = 32'($urandom_range(4 * DEPTH, 4 * DEPTH + 255));
      xfer(wr, a, $urandom, wr ? "rand_wr" : "rand_rd");
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end
    for (int i = 0; i < DEPTH; i++) xfer(1'b0, 32'(4 * i), '0, "final_rd");

    idle(2);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
